instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch unit with stall, branch redirect and squash
module instruction_fetch #(
    parameter logic [63:0] RESET_VECTOR = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] PC_Out,
    output logic        fetch_valid
);

    // REQ: request presented; WAIT: response pending; VALID: word presented;
    // DROP: response pending but squashed by a redirect
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [63:0] pc_out_q, pc_out_n;
    logic        valid_q, valid_n;
    logic [63:0] target;

    // Redirect addresses are word aligned; the low two bits are dropped
    assign target = branch_target & ~64'h3;

    assign imem_req    = (state == S_REQ);
    assign imem_addr   = imem_req ? pc : 64'h0;
    assign fetch_valid = valid_q;
    assign instruction = valid_q ? instr_q : 32'h0;
    assign PC_Out      = valid_q ? pc_out_q : 64'h0;

    // State and datapath registers; reset abandons any outstanding request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_VECTOR;
            instr_q  <= 32'h0;
            pc_out_q <= 64'h0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            instr_q  <= instr_n;
            pc_out_q <= pc_out_n;
            valid_q  <= valid_n;
        end
    end

    // Next-state and datapath update; branch always wins over stall
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        instr_n  = instr_q;
        pc_out_n = pc_out_q;
        valid_n  = valid_q;
        case (state)
            S_REQ: begin
                if (branch_taken) begin
                    pc_n = target;
                    if (imem_ready) state_n = S_DROP;
                end else if (imem_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    pc_n    = target;
                    state_n = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    instr_n  = imem_rdata;
                    pc_out_n = pc;
                    valid_n  = 1'b1;
                    state_n  = S_VALID;
                end
            end
            S_VALID: begin
                if (branch_taken) begin
                    pc_n     = target;
                    valid_n  = 1'b0;
                    instr_n  = 32'h0;
                    pc_out_n = 64'h0;
                    state_n  = S_REQ;
                end else if (!pc_stall) begin
                    pc_n     = pc + 64'd4;
                    valid_n  = 1'b0;
                    instr_n  = 32'h0;
                    pc_out_n = 64'h0;
                    state_n  = S_REQ;
                end
            end
            S_DROP: begin
                if (branch_taken) pc_n = target;
                if (imem_rvalid) state_n = S_REQ;
            end
            default: state_n = S_REQ;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench with a transaction-level fetch model
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_stall, branch_taken, imem_ready, imem_rvalid;
    logic [63:0] branch_target;
    logic [31:0] imem_rdata;
    logic        imem_req, fetch_valid;
    logic [63:0] imem_addr, PC_Out;
    logic [31:0] instruction;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.RESET_VECTOR(64'h0)) dut (
        .clk(clk), .reset(reset), .pc_stall(pc_stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .PC_Out(PC_Out), .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pc, whether a request is outstanding (and squashed), and a presented word
    logic [63:0] m_pc, m_addr;
    logic        m_out, m_sq, m_pres;
    logic [31:0] m_word;
    logic [63:0] tgt;
    assign tgt = {branch_target[63:2], 2'b00};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc <= 64'h0; m_out <= 1'b0; m_sq <= 1'b0;
            m_pres <= 1'b0; m_word <= 32'h0; m_addr <= 64'h0;
        end else if (m_pres) begin
            if (branch_taken) begin
                m_pc <= tgt; m_pres <= 1'b0;
            end else if (!pc_stall) begin
                m_pc <= m_pc + 64'd4; m_pres <= 1'b0;
            end
        end else if (!m_out) begin
            if (branch_taken) m_pc <= tgt;
            if (imem_ready) begin
                m_out <= 1'b1; m_sq <= branch_taken;
            end
        end else begin
            if (imem_rvalid) begin
                m_out <= 1'b0;
                if (!m_sq && !branch_taken) begin
                    m_pres <= 1'b1; m_word <= imem_rdata; m_addr <= m_pc;
                end
            end
            if (branch_taken) begin
                m_pc <= tgt; m_sq <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_req", {63'h0, imem_req}, {63'h0, !m_out && !m_pres});
            chk("cmp_addr", imem_addr, (!m_out && !m_pres) ? m_pc : 64'h0);
            chk("cmp_valid", {63'h0, fetch_valid}, {63'h0, m_pres});
            chk("cmp_instr", {32'h0, instruction}, {32'h0, m_pres ? m_word : 32'h0});
            chk("cmp_pcout", PC_Out, m_pres ? m_addr : 64'h0);
        end
    end

    // Apply inputs for one edge; returns 1 time unit after that edge
    task automatic step(input logic st, input logic br, input logic [63:0] t,
                        input logic rdy, input logic rv, input logic [31:0] rd);
        pc_stall = st; branch_taken = br; branch_target = t;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        @(posedge clk); #1;
        pc_stall = 0; branch_taken = 0; imem_ready = 0; imem_rvalid = 0;
    endtask

    initial begin
        reset = 1; pc_stall = 0; branch_taken = 0; branch_target = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_req", {63'h0, imem_req}, 64'h1);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", {63'h0, fetch_valid}, 64'h0);
        chk("rst_instr", {32'h0, instruction}, 64'h0);
        chk("rst_pcout", PC_Out, 64'h0);

        // First fetch at minimum latency
        step(0, 0, 0, 1, 0, 0);
        chk("lat_req_low", {63'h0, imem_req}, 64'h0);
        step(0, 0, 0, 0, 1, 32'h00500093);
        chk("first_valid", {63'h0, fetch_valid}, 64'h1);
        chk("first_instr", {32'h0, instruction}, 64'h00500093);
        chk("first_pcout", PC_Out, 64'h0);
        step(0, 0, 0, 0, 0, 0);
        chk("next_addr4", imem_addr, 64'h4);

        // Stall while presenting PC 8
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h11111111);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'hAAAA5555);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 32'h0BAD0BAD);
        chk("stall_pcout", PC_Out, 64'h8);
        chk("stall_instr", {32'h0, instruction}, 64'hAAAA5555);
        chk("stall_valid", {63'h0, fetch_valid}, 64'h1);
        step(0, 0, 0, 0, 0, 0);
        chk("after_stall_addr", imem_addr, 64'hC);

        // Branch during WAIT at PC 0x10 -> squashed response
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h22222222);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 64'h103, 0, 0, 0);
        chk("drop_req", {63'h0, imem_req}, 64'h0);
        step(0, 0, 0, 0, 1, 32'hDEADBEEF);
        chk("drop_valid", {63'h0, fetch_valid}, 64'h0);
        chk("drop_addr", imem_addr, 64'h100);

        // Branch beats stall in VALID
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h12345678);
        step(1, 1, 64'h200, 0, 0, 0);
        chk("brstall_valid", {63'h0, fetch_valid}, 64'h0);
        chk("brstall_addr", imem_addr, 64'h200);

        // Backpressure at PC 0x20
        step(0, 1, 64'h20, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("bp_addr", imem_addr, 64'h20);
        end

        // Wrap from the top of the address space
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        chk("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h00000013);
        chk("wrap_pcout", PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_addr0", imem_addr, 64'h0);

        // Stray rvalid and stall in REQ have no effect
        step(1, 0, 0, 0, 1, 32'h33333333);
        chk("stray_req", {63'h0, imem_req}, 64'h1);
        chk("stray_valid", {63'h0, fetch_valid}, 64'h0);

        // Branch accepted in REQ -> DROP, re-branch in DROP, then WAIT branch with rvalid
        step(0, 1, 64'h40, 1, 0, 0);
        chk("reqbr_drop", {63'h0, imem_req}, 64'h0);
        step(0, 1, 64'h44, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h44444444);
        chk("dropbr_addr", imem_addr, 64'h44);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 64'h80, 0, 1, 32'h55555555);
        chk("waitbr_rv_addr", imem_addr, 64'h80);
        chk("waitbr_rv_valid", {63'h0, fetch_valid}, 64'h0);

        // Reset mid-WAIT, then stray response after release
        step(0, 0, 0, 1, 0, 0);
        #2 reset = 1;
        @(posedge clk); #1;
        reset = 0;
        step(0, 0, 0, 0, 1, 32'h66666666);
        chk("rst_mid_addr", imem_addr, 64'h0);
        chk("rst_mid_req", {63'h0, imem_req}, 64'h1);
        chk("rst_mid_valid", {63'h0, fetch_valid}, 64'h0);
        step(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
